// File: rtl/ext_int_controller.sv
// External-interrupt front end for INT0/INT1: synchronise, debounce, sense, flag, mask and
// present a single prioritised request to the interrupt handler over a memory-mapped interface.
module ext_int_controller #(
    parameter int                      ADDRESS_BITS    = 32,
    parameter int                      DEBOUNCE_CYCLES = 4,
    parameter int                      DEB_CNT_BITS    = 8,
    parameter logic [ADDRESS_BITS-1:0] EIFR_ADDR       = 32'h2070,
    parameter logic [ADDRESS_BITS-1:0] EIMSK_ADDR      = 32'h2074,
    parameter logic [ADDRESS_BITS-1:0] EICRA_ADDR      = 32'h2078
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    PIND2_in,
    input  logic                    PIND3_in,
    input  logic [ADDRESS_BITS-1:0] d_mem_address_in,
    input  logic [7:0]              d_mem_data_in,
    input  logic                    d_mem_write,
    input  logic                    d_mem_read,
    output logic [7:0]              reg_read_data,
    output logic                    reg_read_hit,
    input  logic                    irq_ack,
    output logic                    I_request,
    output logic                    irq_id,
    output logic [7:0]              EIMSK
);

    typedef enum logic {
        S_IDLE,
        S_SERVICE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       id_next;
    logic       in_service;

    logic [1:0] pins;
    logic [1:0] sync_meta;
    logic [1:0] sync_out;
    logic [1:0] deb;
    logic [1:0] prev;
    logic [1:0] fall;
    logic [1:0] rise;

    logic [3:0] isc;
    logic [1:0] msk;
    logic [1:0] flags;
    logic [1:0] flags_next;
    logic [1:0] set_evt;
    logic [1:0] clr_evt;
    logic [1:0] pending;
    logic [1:0] req;

    logic       hit_eifr;
    logic       hit_eimsk;
    logic       hit_eicra;
    logic       unused_data_bits;

    assign pins = {PIND3_in, PIND2_in};

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_meta <= 2'b11;
            sync_out  <= 2'b11;
        end else begin
            sync_meta <= pins;
            sync_out  <= sync_meta;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign deb = sync_out;
        end else begin : g_debounce
            localparam logic [DEB_CNT_BITS-1:0] DEB_LAST = DEB_CNT_BITS'(DEBOUNCE_CYCLES - 1);

            logic [DEB_CNT_BITS-1:0] deb_cnt [2];
            logic [1:0]              deb_q;

            // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    deb_q      <= 2'b11;
                    deb_cnt[0] <= '0;
                    deb_cnt[1] <= '0;
                end else begin
                    for (int n = 0; n < 2; n++) begin
                        if (sync_out[n] == deb_q[n]) begin
                            deb_cnt[n] <= '0;
                        end else if (deb_cnt[n] == DEB_LAST) begin
                            deb_q[n]   <= sync_out[n];
                            deb_cnt[n] <= '0;
                        end else begin
                            deb_cnt[n] <= deb_cnt[n] + DEB_CNT_BITS'(1);
                        end
                    end
                end
            end

            assign deb = deb_q;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev <= 2'b11;
        end else begin
            prev <= deb;
        end
    end

    assign fall = prev & ~deb;
    assign rise = ~prev & deb;

    assign hit_eifr  = (d_mem_address_in == EIFR_ADDR);
    assign hit_eimsk = (d_mem_address_in == EIMSK_ADDR);
    assign hit_eicra = (d_mem_address_in == EICRA_ADDR);

    always_comb begin
        set_evt = '0;
        pending = '0;
        for (int n = 0; n < 2; n++) begin
            unique case (isc[2*n +: 2])
                2'b00: begin
                    set_evt[n] = 1'b0;
                    pending[n] = ~deb[n];
                end
                2'b01: begin
                    set_evt[n] = fall[n] | rise[n];
                    pending[n] = flags[n];
                end
                2'b10: begin
                    set_evt[n] = fall[n];
                    pending[n] = flags[n];
                end
                default: begin
                    set_evt[n] = rise[n];
                    pending[n] = flags[n];
                end
            endcase
        end
    end

    // A set event in the same cycle outranks clearing by write or by acknowledge.
    always_comb begin
        clr_evt = '0;
        if (d_mem_write && hit_eifr) begin
            clr_evt = d_mem_data_in[1:0];
        end
        if (irq_ack && in_service) begin
            clr_evt[irq_id] = 1'b1;
        end
        flags_next = (flags & ~clr_evt) | set_evt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            isc   <= '0;
            msk   <= '0;
            flags <= '0;
        end else begin
            flags <= flags_next;
            if (d_mem_write && hit_eicra) begin
                isc <= d_mem_data_in[3:0];
            end
            if (d_mem_write && hit_eimsk) begin
                msk <= d_mem_data_in[1:0];
            end
        end
    end

    assign req        = msk & pending;
    assign in_service = (state == S_SERVICE);

    // Arbitration only happens from idle, so a source in service is never pre-empted.
    always_comb begin
        state_next = state;
        id_next    = irq_id;
        unique case (state)
            S_IDLE: begin
                if (|req) begin
                    state_next = S_SERVICE;
                    id_next    = ~req[0];
                end
            end
            S_SERVICE: begin
                if (irq_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            irq_id    <= 1'b0;
            I_request <= 1'b0;
        end else begin
            state     <= state_next;
            irq_id    <= id_next;
            I_request <= (state_next == S_SERVICE);
        end
    end

    always_comb begin
        reg_read_data = '0;
        if (hit_eifr) begin
            reg_read_data = {6'b0, flags};
        end else if (hit_eimsk) begin
            reg_read_data = {6'b0, msk};
        end else if (hit_eicra) begin
            reg_read_data = {4'b0, isc};
        end
    end

    assign reg_read_hit     = d_mem_read & (hit_eifr | hit_eimsk | hit_eicra);
    assign EIMSK            = {6'b0, msk};
    assign unused_data_bits = ^d_mem_data_in[7:4];

endmodule

// File: tb/tb_ext_int_controller.sv
// Self-checking bench for ext_int_controller: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model built from pin/level histories.
module tb_ext_int_controller;

    localparam int          DEB     = 4;
    localparam logic [31:0] EIFR_A  = 32'h2070;
    localparam logic [31:0] EIMSK_A = 32'h2074;
    localparam logic [31:0] EICRA_A = 32'h2078;

    logic        clock = 1'b0;
    logic        reset;
    logic        PIND2_in;
    logic        PIND3_in;
    logic [31:0] d_mem_address_in;
    logic [7:0]  d_mem_data_in;
    logic        d_mem_write;
    logic        d_mem_read;
    logic [7:0]  reg_read_data;
    logic        reg_read_hit;
    logic        irq_ack;
    logic        I_request;
    logic        irq_id;
    logic [7:0]  EIMSK;

    int          checks = 0;
    int          errors = 0;
    logic        pin2_v = 1'b1;
    logic        pin3_v = 1'b1;
    logic [7:0]  last_read;

    logic [1:0]  pin_hist [$];
    logic [1:0]  deb_hist [$];
    logic [3:0]  m_isc;
    logic [1:0]  m_msk;
    logic [1:0]  m_flags;
    logic        m_busy;
    logic        m_id;

    always #5 clock = ~clock;

    ext_int_controller #(
        .ADDRESS_BITS(32),
        .DEBOUNCE_CYCLES(DEB),
        .DEB_CNT_BITS(8),
        .EIFR_ADDR(EIFR_A),
        .EIMSK_ADDR(EIMSK_A),
        .EICRA_ADDR(EICRA_A)
    ) dut (
        .clock(clock),
        .reset(reset),
        .PIND2_in(PIND2_in),
        .PIND3_in(PIND3_in),
        .d_mem_address_in(d_mem_address_in),
        .d_mem_data_in(d_mem_data_in),
        .d_mem_write(d_mem_write),
        .d_mem_read(d_mem_read),
        .reg_read_data(reg_read_data),
        .reg_read_hit(reg_read_hit),
        .irq_ack(irq_ack),
        .I_request(I_request),
        .irq_id(irq_id),
        .EIMSK(EIMSK)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [31:0] a);
        case (a)
            EIFR_A:  return {6'b0, m_flags};
            EIMSK_A: return {6'b0, m_msk};
            EICRA_A: return {4'b0, m_isc};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        pin_hist = {};
        for (int i = 0; i < DEB + 2; i++) pin_hist.push_front(2'b11);
        deb_hist = {2'b11, 2'b11};
        m_isc   = '0;
        m_msk   = '0;
        m_flags = '0;
        m_busy  = 1'b0;
        m_id    = 1'b0;
    endtask

    // One clock edge of the reference: pin_hist[0] is the pin seen at the previous edge, so the
    // synchronised value in play now is pin_hist[1]; a level flips once DEB such samples disagree.
    task automatic model_edge(input logic rst, input logic [31:0] a, input logic [7:0] data,
                              input logic wr, input logic ack, input logic [1:0] pins);
        logic [1:0] deb_now, deb_old, fall, rise, pend, req, set_ev, clr, deb_new;
        logic [1:0] isc_n;
        bit         all_diff;
        if (!rst) begin
            model_reset();
            return;
        end
        deb_now = deb_hist[0];
        deb_old = deb_hist[1];
        fall    = deb_old & ~deb_now;
        rise    = ~deb_old & deb_now;
        for (int n = 0; n < 2; n++) begin
            isc_n     = m_isc[2*n +: 2];
            pend[n]   = (isc_n == 2'b00) ? ~deb_now[n] : m_flags[n];
            set_ev[n] = ((isc_n == 2'b01) && (fall[n] || rise[n])) ||
                        ((isc_n == 2'b10) && fall[n]) ||
                        ((isc_n == 2'b11) && rise[n]);
            all_diff = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
                if (pin_hist[j][n] == deb_now[n]) all_diff = 1'b0;
            end
            deb_new[n] = all_diff ? ~deb_now[n] : deb_now[n];
        end
        req = m_msk & pend;
        clr = '0;
        if (wr && a == EIFR_A) clr = data[1:0];
        if (ack && m_busy) clr[m_id] = 1'b1;
        m_flags = (m_flags & ~clr) | set_ev;
        if (wr && a == EICRA_A) m_isc = data[3:0];
        if (wr && a == EIMSK_A) m_msk = data[1:0];
        if (!m_busy) begin
            if (req != 2'b00) begin
                m_busy = 1'b1;
                m_id   = ~req[0];
            end
        end else if (ack) begin
            m_busy = 1'b0;
        end
        pin_hist.push_front(pins);
        void'(pin_hist.pop_back());
        deb_hist.push_front(deb_new);
        void'(deb_hist.pop_back());
    endtask

    task automatic applyStimulus(input logic rst, input logic [31:0] a, input logic [7:0] data,
                                 input logic wr, input logic rd, input logic ack);
        @(negedge clock);
        reset            = rst;
        PIND2_in         = pin2_v;
        PIND3_in         = pin3_v;
        d_mem_address_in = a;
        d_mem_data_in    = data;
        d_mem_write      = wr;
        d_mem_read       = rd;
        irq_ack          = ack;
        #1;
        last_read = reg_read_data;
        checkOutput("read_hit", reg_read_hit, rd && (a == EIFR_A || a == EIMSK_A || a == EICRA_A));
        if (rd) checkOutput("read_data", reg_read_data, model_read(a));
        @(posedge clock);
        model_edge(rst, a, data, wr, ack, {pin3_v, pin2_v});
        #1;
        checkOutput("i_request", I_request, m_busy);
        checkOutput("irq_id", irq_id, m_id);
        checkOutput("eimsk", EIMSK, {6'b0, m_msk});
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [7:0] data);
        applyStimulus(1'b1, a, data, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic read_expect(input string tag, input logic [31:0] a, input logic [7:0] expected);
        applyStimulus(1'b1, a, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput(tag, last_read, expected);
    endtask

    task automatic ack_cycle();
        applyStimulus(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        pin2_v = 1'b1;
        pin3_v = 1'b1;
        repeat (n) applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_request(input string tag);
        int n = 0;
        while (!I_request && n < 30) begin
            idle(1);
            n++;
        end
        checkOutput({tag, "_seen"}, I_request, 1'b1);
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic        ack;
        reset = 1'b0;
        PIND2_in = 1'b1;
        PIND3_in = 1'b1;
        d_mem_address_in = '0;
        d_mem_data_in = '0;
        d_mem_write = 1'b0;
        d_mem_read = 1'b0;
        irq_ack = 1'b0;
        model_reset();

        // Reset with pins toggling
        for (int i = 0; i < 3; i++) begin
            pin2_v = ~pin2_v;
            pin3_v = ~pin3_v;
            applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        pin2_v = 1'b1;
        pin3_v = 1'b1;
        checkOutput("rst_ireq", I_request, 1'b0);
        checkOutput("rst_eimsk", EIMSK, 8'h00);
        read_expect("rst_eifr", EIFR_A, 8'h00);
        read_expect("rst_eimsk_rd", EIMSK_A, 8'h00);
        read_expect("rst_eicra", EICRA_A, 8'h00);

        // Falling edge on INT0: fixed latency, flag, acknowledge
        write_reg(EICRA_A, 8'h02);
        write_reg(EIMSK_A, 8'h01);
        idle(2);
        pin2_v = 1'b0;
        n = 0;
        do begin
            idle(1);
            n++;
        end while (!I_request && n < 30);
        checkOutput("int0_latency", n, 8);
        checkOutput("int0_id", irq_id, 1'b0);
        read_expect("int0_flag", EIFR_A, 8'h01);
        ack_cycle();
        checkOutput("int0_ack_req", I_request, 1'b0);
        read_expect("int0_flag_clr", EIFR_A, 8'h00);

        // Debounce: 3-cycle glitch ignored, 4-cycle pulse accepted
        do_reset(2);
        write_reg(EICRA_A, 8'h02);
        write_reg(EIMSK_A, 8'h01);
        idle(2);
        pin2_v = 1'b0;
        idle(3);
        pin2_v = 1'b1;
        idle(12);
        read_expect("glitch_flag", EIFR_A, 8'h00);
        checkOutput("glitch_req", I_request, 1'b0);
        pin2_v = 1'b0;
        idle(4);
        pin2_v = 1'b1;
        idle(10);
        read_expect("pulse_flag", EIFR_A, 8'h01);

        // Priority and hold-off between services
        do_reset(2);
        write_reg(EICRA_A, 8'h0A);
        write_reg(EIMSK_A, 8'h03);
        idle(2);
        pin2_v = 1'b0;
        pin3_v = 1'b0;
        wait_request("prio_first");
        checkOutput("prio_first_id", irq_id, 1'b0);
        ack_cycle();
        checkOutput("prio_gap", I_request, 1'b0);
        idle(1);
        checkOutput("prio_second_req", I_request, 1'b1);
        checkOutput("prio_second_id", irq_id, 1'b1);
        ack_cycle();

        // Write-1-to-clear and set/clear collision
        do_reset(2);
        write_reg(EICRA_A, 8'h05);
        idle(1);
        pin2_v = 1'b0;
        pin3_v = 1'b0;
        idle(12);
        read_expect("w1c_both", EIFR_A, 8'h03);
        write_reg(EIFR_A, 8'h02);
        read_expect("w1c_partial", EIFR_A, 8'h01);
        pin2_v = 1'b1;
        idle(6);
        write_reg(EIFR_A, 8'h01);
        read_expect("w1c_collision", EIFR_A, 8'h01);

        // Level mode on INT1
        do_reset(2);
        write_reg(EICRA_A, 8'h00);
        write_reg(EIMSK_A, 8'h02);
        pin3_v = 1'b0;
        for (int r = 0; r < 3; r++) begin
            wait_request("level");
            checkOutput("level_id", irq_id, 1'b1);
            ack_cycle();
            checkOutput("level_gap", I_request, 1'b0);
            read_expect("level_flag", EIFR_A, 8'h00);
            checkOutput("level_rearm", I_request, 1'b1);
        end
        pin3_v = 1'b1;
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, I_request);
        idle(10);
        checkOutput("level_released", I_request, 1'b0);

        // Randomized traffic
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) pin2_v = ~pin2_v;
            if ($urandom_range(0, 5) == 0) pin3_v = ~pin3_v;
            case ($urandom_range(0, 3))
                0:       a = EIFR_A;
                1:       a = EIMSK_A;
                2:       a = EICRA_A;
                default: a = $urandom;
            endcase
            ack = I_request ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            n = int'($urandom_range(0, 9));
            applyStimulus($urandom_range(0, 499) != 0, a, 8'($urandom), n == 0, n >= 1 && n <= 3, ack);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
